// File: rtl/data_path_sequencer.sv
// rtl/data_path_sequencer.sv - multi-cycle instruction sequencer for the mux/register-file datapath
//
// Purpose: accepts one 6-bit instruction per start request and steps it through
//   IDLE -> DECODE -> READ -> [EXEC] -> WB -> DONE, driving the datapath controls.
// Ports:
//   clk      in   1  system clock
//   rst_n    in   1  synchronous active-low reset
//   start    in   1  launch request, honoured only in IDLE
//   instr    in   6  [5:4] op, [3:2] rd, [1:0] rs
//   mux_sel  out  2  00 zero, 01 sw_in, 10 regfile read, 11 ALU
//   rd_addr  out  2  register-file read address
//   alu_go   out  1  high throughout EXEC
//   reg_we   out  4  one-hot register write enable, only in WB
//   busy     out  1  high in every state except IDLE
//   done     out  1  one-cycle pulse in DONE

module data_path_sequencer #(
    parameter int ALU_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] instr,
    output logic [1:0] mux_sel,
    output logic [1:0] rd_addr,
    output logic       alu_go,
    output logic [3:0] reg_we,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_READ   = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [3:0] EXEC_LOAD = 4'(ALU_CYCLES - 1);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;
    logic [5:0] r_instr;

    logic [1:0] w_op;
    logic [1:0] w_rd;
    logic [1:0] w_rs;
    logic       w_active;

    assign w_op = r_instr[5:4];
    assign w_rd = r_instr[3:2];
    assign w_rs = r_instr[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_instr <= 6'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_instr <= instr;
            end
            // Counter is loaded on the READ->EXEC edge so EXEC lasts exactly ALU_CYCLES.
            if (r_state == S_READ) begin
                r_cnt <= EXEC_LOAD;
            end else if (r_state == S_EXEC && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_DECODE;
            S_DECODE: w_next = S_READ;
            S_READ:   w_next = (w_op == 2'b11) ? S_EXEC : S_WB;
            S_EXEC:   if (r_cnt == 4'd0) w_next = S_WB;
            S_WB:     w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Mux select and read address stay at their opcode values from READ through DONE,
    // and are zero in IDLE/DECODE so the datapath sees a zero source while idle.
    assign w_active = (r_state == S_READ) || (r_state == S_EXEC) ||
                      (r_state == S_WB)   || (r_state == S_DONE);

    always_comb begin
        mux_sel = 2'b00;
        rd_addr = 2'b00;
        alu_go  = 1'b0;
        reg_we  = 4'b0000;
        busy    = (r_state != S_IDLE);
        done    = (r_state == S_DONE);
        if (w_active) begin
            mux_sel = w_op;
            // Only MOV and ALU read the register file; CLR/LDSW keep address 0.
            if (w_op[1]) begin
                rd_addr = w_rs;
            end
        end
        if (r_state == S_EXEC) begin
            alu_go = 1'b1;
        end
        if (r_state == S_WB) begin
            reg_we = 4'b0001 << w_rd;
        end
    end

endmodule

// File: tb/tb_data_path_sequencer.sv
// tb/tb_data_path_sequencer.sv - scoreboard bench for data_path_sequencer

module tb_data_path_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] instr;
    logic [1:0] mux_sel;
    logic [1:0] rd_addr;
    logic       alu_go;
    logic [3:0] reg_we;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_err = 0;
    bit stim_done = 1'b0;

    logic [10:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    data_path_sequencer #(.ALU_CYCLES(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .instr   (instr),
        .mux_sel (mux_sel),
        .rd_addr (rd_addr),
        .alu_go  (alu_go),
        .reg_we  (reg_we),
        .busy    (busy),
        .done    (done)
    );

    function automatic logic [10:0] ex(input logic [1:0] m, input logic [1:0] ra,
                                       input logic go, input logic [3:0] we,
                                       input logic bz, input logic dn);
        return {m, ra, go, we, bz, dn};
    endfunction

    // Drive inputs for one cycle, queue what the outputs must be during that cycle.
    task automatic step(input logic r, input logic s, input logic [5:0] in,
                        input logic [10:0] e, input bit chk, input string tag);
        rst_n = r;
        start = s;
        instr = in;
        if (chk) begin
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
        @(posedge clk);
        #1;
    endtask

    // One full instruction: launch cycle (IDLE) through DONE. nexec = ALU cycles (0 for non-ALU).
    task automatic run(input logic [5:0] ins, input int nexec, input logic bstart,
                       input logic [5:0] binstr, input logic dstart, input string tag);
        logic [1:0] op;
        logic [1:0] ra;
        logic [3:0] we;
        op = ins[5:4];
        ra = op[1] ? ins[1:0] : 2'b00;
        we = 4'b0001 << ins[3:2];
        step(1'b1, 1'b1, ins, ex(2'b00, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0), 1'b1, {tag, "_idle"});
        step(1'b1, bstart, binstr, ex(2'b00, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0), 1'b1, {tag, "_decode"});
        step(1'b1, bstart, binstr, ex(op, ra, 1'b0, 4'h0, 1'b1, 1'b0), 1'b1, {tag, "_read"});
        for (int i = 0; i < nexec; i++) begin
            step(1'b1, bstart, binstr, ex(op, ra, 1'b1, 4'h0, 1'b1, 1'b0), 1'b1, {tag, "_exec"});
        end
        step(1'b1, bstart, binstr, ex(op, ra, 1'b0, we, 1'b1, 1'b0), 1'b1, {tag, "_wb"});
        step(1'b1, dstart, binstr, ex(op, ra, 1'b0, 4'h0, 1'b1, 1'b1), 1'b1, {tag, "_done"});
    endtask

    // Monitor: compare every cycle that has a queued expectation.
    initial begin
        logic [10:0] act;
        logic [10:0] e;
        string       t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                act = {mux_sel, rd_addr, alu_go, reg_we, busy, done};
                n_vec++;
                if (act !== e) begin
                    n_err++;
                    $display("FAIL %s: got mux=%b rd=%b go=%b we=%b busy=%b done=%b, want mux=%b rd=%b go=%b we=%b busy=%b done=%b",
                             t, act[10:9], act[8:7], act[6], act[5:2], act[1], act[0],
                             e[10:9], e[8:7], e[6], e[5:2], e[1], e[0]);
                end
            end
        end
    end

    localparam logic [10:0] Z = 11'd0;

    initial begin
        // Reset held 3 cycles with start high; outputs undefined until the first reset edge.
        step(1'b0, 1'b1, 6'b11_11_11, Z, 1'b0, "rst0");
        step(1'b0, 1'b1, 6'b11_11_11, Z, 1'b1, "rst1");
        step(1'b0, 1'b1, 6'b11_11_11, Z, 1'b1, "rst2");
        step(1'b1, 1'b0, 6'b00_00_00, Z, 1'b1, "rst_release");
        step(1'b1, 1'b0, 6'b00_00_00, Z, 1'b1, "idle");

        // LDSW R2: mux 01 in cycles 2-4, we 0100 in cycle 3, done in cycle 4.
        run(6'b01_10_00, 0, 1'b0, 6'b00_00_00, 1'b0, "ldsw");
        step(1'b1, 1'b0, 6'b00_00_00, Z, 1'b1, "ldsw_after");

        // ALU R1 <- f(R3), ALU_CYCLES=3: rd_addr 3, alu_go 3 cycles, we 0010 in cycle 6, done cycle 7.
        run(6'b11_01_11, 3, 1'b0, 6'b00_00_00, 1'b0, "alu");
        step(1'b1, 1'b0, 6'b00_00_00, Z, 1'b1, "alu_after");

        // MOV R2,R2 with start held and instr changed while busy: ignored, one write only.
        run(6'b10_10_10, 0, 1'b1, 6'b11_00_01, 1'b0, "mov");
        step(1'b1, 1'b0, 6'b11_00_01, Z, 1'b1, "mov_after1");
        step(1'b1, 1'b0, 6'b11_00_01, Z, 1'b1, "mov_after2");

        // Abort during EXEC: ALU R0 <- f(R1), reset asserted in the first EXEC cycle.
        step(1'b1, 1'b1, 6'b11_00_01, Z, 1'b1, "abort_idle");
        step(1'b1, 1'b0, 6'b00_00_00, ex(2'b00, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0), 1'b1, "abort_decode");
        step(1'b1, 1'b0, 6'b00_00_00, ex(2'b11, 2'b01, 1'b0, 4'h0, 1'b1, 1'b0), 1'b1, "abort_read");
        step(1'b0, 1'b0, 6'b00_00_00, ex(2'b11, 2'b01, 1'b1, 4'h0, 1'b1, 1'b0), 1'b1, "abort_exec");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 6'b00_00_00, Z, 1'b1, "abort_quiet");
        end
        // Fresh CLR R3: we 1000 with mux 00.
        run(6'b00_11_00, 0, 1'b0, 6'b00_00_00, 1'b0, "clr_r3");
        step(1'b1, 1'b0, 6'b00_00_00, Z, 1'b1, "clr_after");

        // Back-to-back CLR with start held high: done every 5 cycles.
        run(6'b00_00_00, 0, 1'b1, 6'b01_01_01, 1'b1, "b2b0");
        run(6'b00_01_00, 0, 1'b1, 6'b01_01_01, 1'b1, "b2b1");
        run(6'b00_10_00, 0, 1'b1, 6'b01_01_01, 1'b0, "b2b2");
        step(1'b1, 1'b0, 6'b00_00_00, Z, 1'b1, "b2b_after");
        step(1'b1, 1'b0, 6'b00_00_00, Z, 1'b1, "final_idle");
        stim_done = 1'b1;
    end

    initial begin
        int guard;
        guard = 0;
        wait (stim_done);
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: stimulus did not complete, want completion");
        $fatal(1, "timeout");
    end

endmodule
